ahb8_arbiter: RTL
=================

# ahb8_arbiter

Two-master arbiter for the shrinked 8-bit AHB inside the KC-LS1u SoC. It shares one slave-side bus (FSB8 controller plus on-chip peripheral decode) between master 0 (CPU core) and master 1 (DMA/debug master). It grants ownership at transfer boundaries, forwards only the owner's request signals, and routes hready/hrdata back to the owner. A hold counter bounds how long one master can starve the other.

## Interface
- ADDR_W, 24, haddr width (32 when PAE is enabled)
- HOLD_MAX, 16, completed single transfers an owner may issue while the other master waits before forced release; minimum 1
- hclk  in  1  bus clock, sole clock domain
- hreset_n  in  1  asynchronous active-low reset
- m0_req, m1_req  in  1 each  bus request, level
- m0_gnt, m1_gnt  out  1 each  ownership grant, registered
- mN_haddr  in  ADDR_W  master address
- mN_hwrite, mN_htrans, mN_hburst  in  1 each  write / transfer active / block burst
- mN_hwdata  in  8  master write data
- mN_hready  out  1  owner: slave hready; non-owner: 0
- mN_hrdata  out  8  slave hrdata broadcast to both masters
- haddr  out  ADDR_W  owner haddr; 0 when no owner
- hwrite, hburst  out  1 each  owner values; 0 when no owner
- htrans  out  1  owner htrans AND owner gnt; 0 otherwise
- hwdata  out  8  owner hwdata
- hready  in  1  slave ready
- hrdata  in  8  slave read data
- arb_owner  out  2  status: 00 none, 01 M0, 10 M1

## Operation
- A transfer completes on any cycle where slave-side htrans=1 and hready=1.
- FSM states:
  - IDLE: no grant. If any req is high, pick a winner and move to OWN0/OWN1 on the next edge. The gnt goes high in the same edge.
  - OWN0 / OWN1: mux the owner's signals.
  - Exit to IDLE when the owner's req=0 and no transfer is pending (slave htrans=0, or a completing transfer this cycle).
  - Forced exit to IDLE when the other req=1, hold_cnt==HOLD_MAX, and a transfer completes this cycle with hburst=0.
- hold_cnt:
  - Cleared on grant.
  - Increments on each completed transfer while the other master requests.
  - Saturates at HOLD_MAX.
  - Not incremented while hburst=1. Block bursts are never preempted.
- Owner gnt drops the edge it leaves OWNx. Slave htrans is masked from that edge on.
- A preempted master keeps req high. Its unfinished next transfer sees mN_hready=0 and is re-presented after re-grant.
- Handover always passes through one IDLE cycle. There is no back-to-back owner switch.
- Owner drops req while htrans=1, hready=0: grant is held until hready=1. The transfer is never truncated.
- last_owner register: updated on every grant. Used only by round-robin.

## Timing
- Reset values:
  - state IDLE
  - m0_gnt=m1_gnt=0
  - arb_owner=00
  - hold_cnt=0
  - last_owner=M1
  - all slave-side outputs 0
- Request-to-grant latency from IDLE: 1 cycle (req sampled high at edge k, gnt high after edge k+1).
- Release-to-next-grant: 2 cycles (OWNx → IDLE → OWNy).
- Slave-side request mux and mN_hready/hrdata return are combinational from the registered owner. No added data latency.
- Reset asserted mid-transfer: everything returns to reset values immediately (async). The slave sees htrans=0.

## Configuration
- ARB_RR_EN defined: round-robin. On simultaneous requests in IDLE, the master that is not last_owner wins.
- ARB_RR_EN undefined: fixed priority. M0 always wins simultaneous requests. last_owner logic is compiled out. HOLD_MAX preemption still applies to both masters.

## Structure
- Shared package ls1u_bus_pkg holds:
  - arbiter state enum (IDLE, OWN0, OWN1)
  - owner encoding constants (OWN_NONE=2'b00, OWN_M0=2'b01, OWN_M1=2'b10)
  - default ADDR_W
- One sub-module, ahb8_arb_pick: combinational winner select from m0_req, m1_req and last_owner. This is the only part that differs under ARB_RR_EN.
- FSM, hold counter and mux stay in ahb8_arbiter.

## Test plan
- Reset release, m0_req=1 at cycle 2 → m0_gnt=1 at cycle 3, arb_owner=01, haddr follows m0_haddr=24'hC00500.
- Both req rise together from IDLE → M0 granted. M0 drops req → 1 IDLE cycle → M1 granted. With ARB_RR_EN, a repeat simultaneous request then grants M1 if last_owner=M0.
- M0 issues continuous singles (hburst=0), M1 requesting, HOLD_MAX=4 → m0_gnt falls after the 4th completion, m1_gnt rises 2 cycles later. The masked M0 5th transfer never reaches the slave.
- M0 burst (hburst=1) of 20 transfers with M1 requesting → no preemption until hburst=0 and hold condition met.
- Owner drops req while hready=0 for 3 cycles → grant held, transfer completes, then IDLE.
- hreset_n asserted during M1 write → outputs zero asynchronously. After release, M1 (still requesting) is re-granted in 1 cycle.

Source files
------------

// File: rtl/ls1u_bus_pkg.sv
// Shared definitions for the KC-LS1u 8-bit AHB fabric.
//   arb_state_e : arbiter FSM states, encoded so the state value is also the
//                 arb_owner status code (00 none, 01 M0, 10 M1)
//   OWN_*       : owner encoding constants
//   ADDR_W_DEFAULT : default haddr width (32 when PAE is enabled)
package ls1u_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_M0   = 2'b01;
  localparam logic [1:0] OWN_M1   = 2'b10;

  localparam int ADDR_W_DEFAULT = 24;

endpackage

// File: rtl/ahb8_arb_pick.sv
// Winner select for the 8-bit AHB arbiter (combinational).
//   m0_req_i, m1_req_i : level requests
//   defer_i            : master that was force-released and must lose the next
//                        simultaneous arbitration (OWN_NONE if none)
//   last_owner_i       : previous grantee (only with ARB_RR_EN)
//   pick_m1_o          : 1 = M1 wins, 0 = M0 wins (only meaningful if any req)
// Macro ARB_RR_EN: round-robin on simultaneous requests; otherwise M0 wins.
module ahb8_arb_pick
  import ls1u_bus_pkg::*;
(
  input  logic       m0_req_i,
  input  logic       m1_req_i,
  input  logic [1:0] defer_i,
`ifdef ARB_RR_EN
  input  logic [1:0] last_owner_i,
`endif
  output logic       pick_m1_o
);

  always_comb begin
    pick_m1_o = m1_req_i & ~m0_req_i;
    if (m0_req_i && m1_req_i) begin
      // A preempted master yields once, otherwise the hold limit could not
      // stop a higher-priority master from starving the other.
      if (defer_i == OWN_M0)      pick_m1_o = 1'b1;
      else if (defer_i == OWN_M1) pick_m1_o = 1'b0;
      else begin
`ifdef ARB_RR_EN
        pick_m1_o = (last_owner_i == OWN_M0);
`else
        pick_m1_o = 1'b0;
`endif
      end
    end
  end

endmodule

// File: rtl/ahb8_arbiter.sv
// Two-master arbiter for the 8-bit AHB (M0 = CPU, M1 = DMA/debug).
// Grants ownership at transfer boundaries, muxes the owner's request onto the
// slave side, returns hready to the owner only, broadcasts hrdata. A hold
// counter limits how many completed singles an owner may issue while the
// other master waits.
// Ports:
//   hclk, hreset_n               clock, async active-low reset
//   mN_req / mN_gnt              request in / registered grant out
//   mN_haddr,hwrite,htrans,hburst,hwdata   master request signals
//   mN_hready / mN_hrdata        returned ready (owner only) / read data
//   haddr,hwrite,htrans,hburst,hwdata      slave-side request (0 with no owner)
//   hready, hrdata               slave response
//   arb_owner                    00 none, 01 M0, 10 M1
// Macro ARB_RR_EN: round-robin arbitration (see ahb8_arb_pick).
module ahb8_arbiter
  import ls1u_bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int HOLD_MAX = 16
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              m0_req,
  input  logic              m1_req,
  output logic              m0_gnt,
  output logic              m1_gnt,
  input  logic [ADDR_W-1:0] m0_haddr,
  input  logic              m0_hwrite,
  input  logic              m0_htrans,
  input  logic              m0_hburst,
  input  logic [7:0]        m0_hwdata,
  output logic              m0_hready,
  output logic [7:0]        m0_hrdata,
  input  logic [ADDR_W-1:0] m1_haddr,
  input  logic              m1_hwrite,
  input  logic              m1_htrans,
  input  logic              m1_hburst,
  input  logic [7:0]        m1_hwdata,
  output logic              m1_hready,
  output logic [7:0]        m1_hrdata,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic              htrans,
  output logic              hburst,
  output logic [7:0]        hwdata,
  input  logic              hready,
  input  logic [7:0]        hrdata,
  output logic [1:0]        arb_owner
);

  localparam int HW = $clog2(HOLD_MAX + 1);

  arb_state_e  state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]  defer_q, defer_d;
  logic        pick_m1, own_req, oth_req, xfer_done, hold_inc, forced;

`ifdef ARB_RR_EN
  logic [1:0] last_owner_q;
`endif

  ahb8_arb_pick u_pick (
    .m0_req_i     (m0_req),
    .m1_req_i     (m1_req),
    .defer_i      (defer_q),
`ifdef ARB_RR_EN
    .last_owner_i (last_owner_q),
`endif
    .pick_m1_o    (pick_m1)
  );

  // state register
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      defer_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      defer_q <= defer_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n)                              last_owner_q <= OWN_M1;
    else if (state_q == IDLE && (m0_req || m1_req)) last_owner_q <= pick_m1 ? OWN_M1 : OWN_M0;
  end
`endif

  assign own_req   = (state_q == OWN0) ? m0_req : (state_q == OWN1) ? m1_req : 1'b0;
  assign oth_req   = (state_q == OWN0) ? m1_req : (state_q == OWN1) ? m0_req : 1'b0;
  assign xfer_done = htrans & hready;

  // The count includes the transfer completing this cycle, so the release
  // happens on the HOLD_MAX-th completion and the next transfer is masked.
  assign hold_inc = xfer_done & oth_req & ~hburst & (hold_q != HW'(HOLD_MAX));
  assign hold_d   = (state_q == IDLE) ? '0 : hold_q + HW'(hold_inc);
  assign forced   = xfer_done & oth_req & ~hburst & (hold_d == HW'(HOLD_MAX));

  // next state
  always_comb begin
    state_d = state_q;
    defer_d = defer_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d = pick_m1 ? OWN1 : OWN0;
          defer_d = OWN_NONE;
        end
      end
      OWN0, OWN1: begin
        if (forced) begin
          state_d = IDLE;
          defer_d = (state_q == OWN0) ? OWN_M0 : OWN_M1;
        end else if (!own_req && (!htrans || xfer_done)) begin
          // a stalled transfer keeps the grant until hready
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs: combinational from the registered owner
  always_comb begin
    haddr     = '0;
    hwrite    = 1'b0;
    htrans    = 1'b0;
    hburst    = 1'b0;
    hwdata    = '0;
    m0_hready = 1'b0;
    m1_hready = 1'b0;
    case (state_q)
      OWN0: begin
        haddr     = m0_haddr;
        hwrite    = m0_hwrite;
        htrans    = m0_htrans;
        hburst    = m0_hburst;
        hwdata    = m0_hwdata;
        m0_hready = hready;
      end
      OWN1: begin
        haddr     = m1_haddr;
        hwrite    = m1_hwrite;
        htrans    = m1_htrans;
        hburst    = m1_hburst;
        hwdata    = m1_hwdata;
        m1_hready = hready;
      end
      default: ;
    endcase
  end

  assign m0_gnt    = (state_q == OWN0);
  assign m1_gnt    = (state_q == OWN1);
  assign arb_owner = state_q;
  assign m0_hrdata = hrdata;
  assign m1_hrdata = hrdata;

endmodule
